// File: rtl/spi_reg_target.sv
// SPI mode-0 target that bridges an external initiator onto a byte-wide register bus.
// SCLK, MOSI and CS_n are oversampled in the clk_i domain and never used as clocks.
module spi_reg_target #(
  parameter int         ADDR_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  cs_n_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [7:0]            reg_wdata_o,
  output logic                  reg_we_o,
  output logic                  reg_re_o,
  input  logic [7:0]            reg_rdata_i,
  output logic                  active_o
);

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    SKIP
  } spiState_t;

  logic [SYNC_STAGES-1:0] sclkSync_q, mosiSync_q, csSync_q;
  logic                   sclkS, mosiS, csS;
  logic                   sclkRise, sclkFall, byteDone;
  logic [7:0]             rxByte;

  spiState_t              state_q, state_d;
  logic                   isRead_q, isRead_d;
  logic                   sclkPrev_q, sclkPrev_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [6:0]             rxShift_q, rxShift_d;
  logic [6:0]             txShift_q, txShift_d;
  logic [7:0]             txNext_q, txNext_d;
  logic                   miso_q, miso_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   reLoad_q, reLoad_d;

  // CS_n resets high so a reset never looks like a select.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      csSync_q   <= '1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_n_i};
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign rxByte   = {rxShift_q, mosiS};
  assign byteDone = (state_q != IDLE) && sclkRise && (bitCnt_q == 3'd7);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      isRead_q   <= 1'b0;
      sclkPrev_q <= 1'b0;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      txNext_q   <= '0;
      miso_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      reLoad_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      isRead_q   <= isRead_d;
      sclkPrev_q <= sclkPrev_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      txNext_q   <= txNext_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      reLoad_q   <= reLoad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    isRead_d   = isRead_q;
    sclkPrev_d = sclkS;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    txNext_d   = txNext_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    reLoad_d   = re_q;

    // Read data is valid one cycle after the RE strobe; it becomes the next byte to shift out.
    if (reLoad_q) txNext_d = reg_rdata_i;
    if (we_q) addr_d = addr_q + 1'b1;

    if (state_q == IDLE) begin
      miso_d = 1'b1;
      if (!csS) begin
        state_d   = CMD;
        txShift_d = ID_BYTE[6:0];
        miso_d    = ID_BYTE[7];
        txNext_d  = 8'h00;
        bitCnt_d  = '0;
        rxShift_d = '0;
      end
    end else begin
      if (sclkRise) begin
        rxShift_d = rxByte[6:0];
        bitCnt_d  = bitCnt_q + 3'd1;
      end

      // A fall with the counter at zero starts a new byte, so take the queued one.
      if (sclkFall) begin
        if (bitCnt_q == 3'd0) begin
          txShift_d = txNext_q[6:0];
          miso_d    = txNext_q[7];
        end else begin
          txShift_d = {txShift_q[5:0], 1'b0};
          miso_d    = txShift_q[6];
        end
      end
      if (state_q == SKIP) miso_d = 1'b1;

      if (byteDone) begin
        case (state_q)
          CMD: begin
            if (rxByte == CMD_WRITE || rxByte == CMD_READ) begin
              state_d  = ADDR;
              isRead_d = (rxByte == CMD_READ);
              txNext_d = 8'h00;
            end else begin
              state_d  = SKIP;
              txNext_d = 8'hFF;
            end
          end
          ADDR: begin
            addr_d = rxByte[ADDR_WIDTH-1:0];
            if (isRead_q) begin
              state_d = RDATA;
              re_d    = 1'b1;
            end else begin
              state_d  = WDATA;
              txNext_d = 8'h00;
            end
          end
          WDATA: begin
            wdata_d = rxByte;
            we_d    = 1'b1;
          end
          RDATA: begin
            addr_d = addr_q + 1'b1;
            re_d   = 1'b1;
          end
          default: ;
        endcase
      end

      // Deselect ends the transaction; a byte completing in the same cycle keeps its strobe.
      if (csS) begin
        state_d = IDLE;
        miso_d  = 1'b1;
      end
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = ~csS;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign active_o    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_target.sv
// Scoreboard bench for spi_reg_target: an 8-bit-address instance (A) and a 4-bit one (B)
// share SCLK/MOSI and have their own selects and register-bus models.
module tb_spi_reg_target;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       csA = 1'b1;
  logic       csB = 1'b1;
  logic       sel = 1'b0;

  logic       misoA, misoOeA, weA, reA, activeA;
  logic [7:0] addrA, wdataA;
  logic [7:0] rdataA = 8'h00;
  logic       misoB, misoOeB, weB, reB, activeB;
  logic [3:0] addrB;
  logic [7:0] wdataB;
  logic [7:0] rdataB = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } weExp_t;

  weExp_t     weQ[$];
  logic [7:0] reQA[$];
  logic [7:0] reQB[$];
  logic [7:0] misoQ[$];
  int weSeenA = 0;
  int reSeenA = 0;
  int reSeenB = 0;

  always #5 clk = ~clk;

  spi_reg_target dutA (
    .clk_i(clk), .reset_n_i(resetN), .sclk_i(sclk), .mosi_i(mosi), .cs_n_i(csA),
    .miso_o(misoA), .miso_oe_o(misoOeA), .reg_addr_o(addrA), .reg_wdata_o(wdataA),
    .reg_we_o(weA), .reg_re_o(reA), .reg_rdata_i(rdataA), .active_o(activeA)
  );

  spi_reg_target #(.ADDR_WIDTH(4)) dutB (
    .clk_i(clk), .reset_n_i(resetN), .sclk_i(sclk), .mosi_i(mosi), .cs_n_i(csB),
    .miso_o(misoB), .miso_oe_o(misoOeB), .reg_addr_o(addrB), .reg_wdata_o(wdataB),
    .reg_we_o(weB), .reg_re_o(reB), .reg_rdata_i(rdataB), .active_o(activeB)
  );

  // Single point where every comparison is counted and any mismatch is reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Register file model: read data appears the cycle after the RE strobe.
  always @(posedge clk) begin
    if (reA) rdataA <= addrA ^ 8'h5A;
    if (reB) rdataB <= {4'h0, addrB} ^ 8'h5A;
  end

  // Bus monitor: every strobe is matched against the next expected entry.
  always @(negedge clk) begin
    if (resetN) begin
      if (weA) begin
        weSeenA++;
        checkOutput("reDuringWe", {31'd0, reA}, 32'd0);
        if (weQ.size() > 0) begin
          weExp_t e;
          e = weQ.pop_front();
          checkOutput("weAddrData", {addrA, wdataA}, {e.addr, e.data});
        end
      end
      if (reA) begin
        reSeenA++;
        if (reQA.size() > 0) checkOutput("reAddrA", addrA, reQA.pop_front());
      end
      if (reB) begin
        reSeenB++;
        if (reQB.size() > 0) checkOutput("reAddrB", {4'h0, addrB}, reQB.pop_front());
      end
    end
  end

  // One SPI bit at SCLK = CLK/16: MISO is sampled just before the rising edge.
  task automatic spiBit(input logic b, output logic rx);
    mosi = b;
    repeat (8) @(negedge clk);
    rx = sel ? misoB : misoA;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spiBit(tx[i], b);
      rx[i] = b;
    end
  endtask

  // Sends a byte and compares what came back on MISO with the next queued expectation.
  task automatic applyStimulus(input logic [7:0] tx);
    logic [7:0] rx;
    spiByte(tx, rx);
    if (misoQ.size() > 0) checkOutput("misoByte", rx, misoQ.pop_front());
  endtask

  task automatic csLow();
    @(negedge clk);
    if (sel) csB = 1'b0; else csA = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("misoOe", sel ? misoOeB : misoOeA, 1);
  endtask

  task automatic csHigh();
    repeat (4) @(negedge clk);
    if (sel) csB = 1'b1; else csA = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("activeIdle", sel ? activeB : activeA, 0);
    checkOutput("misoOeIdle", sel ? misoOeB : misoOeA, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Miso"}, misoA, 1);
    checkOutput({tag, "MisoOe"}, misoOeA, 0);
    checkOutput({tag, "Addr"}, addrA, 0);
    checkOutput({tag, "Wdata"}, wdataA, 0);
    checkOutput({tag, "We"}, weA, 0);
    checkOutput({tag, "Re"}, reA, 0);
    checkOutput({tag, "Active"}, activeA, 0);
  endtask

  task automatic runWriteTest();
    weSeenA = 0;
    reSeenA = 0;
    weQ.push_back('{8'h10, 8'hAB});
    weQ.push_back('{8'h11, 8'hCD});
    misoQ.push_back(8'hA5);
    misoQ.push_back(8'h00);
    misoQ.push_back(8'h00);
    misoQ.push_back(8'h00);
    csLow();
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    csHigh();
    checkOutput("writeWeCount", weSeenA, 2);
    checkOutput("writeReCount", reSeenA, 0);
  endtask

  initial begin
    logic b;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    checkOutput("resetActiveB", activeB, 0);
    resetN = 1'b1;
    repeat (4) @(negedge clk);

    // Plain write burst
    runWriteTest();

    // Read burst that wraps the 8-bit address
    reSeenA = 0;
    weSeenA = 0;
    reQA = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    misoQ = '{8'hA5, 8'h00, 8'hA4, 8'hA5, 8'h5A};
    csLow();
    applyStimulus(8'h03);
    applyStimulus(8'hFE);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00);
    csHigh();
    checkOutput("readReCount", reSeenA, 4);
    checkOutput("readWeCount", weSeenA, 0);

    // Abort mid-byte, then a fresh write
    weSeenA = 0;
    weQ.push_back('{8'h20, 8'hAB});
    misoQ = '{8'hA5, 8'h00, 8'h00};
    csLow();
    applyStimulus(8'h02);
    applyStimulus(8'h20);
    applyStimulus(8'hAB);
    for (int i = 0; i < 4; i++) spiBit(1'b1, b);
    csHigh();
    checkOutput("abortWeCount", weSeenA, 1);
    weQ.push_back('{8'h30, 8'h11});
    misoQ = '{8'hA5, 8'h00, 8'h00};
    csLow();
    applyStimulus(8'h02);
    applyStimulus(8'h30);
    applyStimulus(8'h11);
    csHigh();
    checkOutput("afterAbortWeCount", weSeenA, 2);

    // Unknown command is skipped
    weSeenA = 0;
    reSeenA = 0;
    misoQ = '{8'hA5, 8'hFF, 8'hFF};
    csLow();
    applyStimulus(8'h55);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    checkOutput("skipActive", activeA, 1);
    csHigh();
    checkOutput("skipWeCount", weSeenA, 0);
    checkOutput("skipReCount", reSeenA, 0);

    // Reset in the middle of a read
    reSeenA = 0;
    reQA = '{8'h40, 8'h41};
    misoQ = '{8'hA5, 8'h00, 8'h40 ^ 8'h5A};
    csLow();
    applyStimulus(8'h03);
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    for (int i = 0; i < 4; i++) spiBit(1'b0, b);
    checkOutput("midReadActive", activeA, 1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checkResetValues("midReset");
    checkOutput("midResetReCount", reSeenA, 2);
    sclk = 1'b0;
    csA = 1'b1;
    repeat (4) @(negedge clk);
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    runWriteTest();

    // Long read burst on the 4-bit address instance
    sel = 1'b1;
    reSeenA = 0;
    weSeenA = 0;
    reSeenB = 0;
    misoQ = '{8'hA5, 8'h00};
    for (int i = 0; i <= 64; i++) begin
      logic [3:0] a;
      a = 4'(4'hC + i);
      reQB.push_back({4'h0, a});
      if (i < 64) misoQ.push_back({4'h0, a} ^ 8'h5A);
    end
    csLow();
    applyStimulus(8'h03);
    applyStimulus(8'hFC);
    for (int i = 0; i < 64; i++) applyStimulus(8'h00);
    csHigh();
    checkOutput("burstReCount", reSeenB, 65);
    checkOutput("burstFinalAddr", addrB, 4'hC);
    checkOutput("idleDutReCount", reSeenA, 0);
    checkOutput("idleDutWeCount", weSeenA, 0);
    checkOutput("misoQueueDrained", misoQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
